// File: rtl/geofence_pkg.sv
// Shared types and width helpers for the geofence block.
//   state_t          : control FSM states (LOAD, SORT, TEST, OUT)
//   CROSS_GUARD_BITS : bits a cross product needs beyond 2*COORD_W
//   cross_width()    : full-precision signed cross-product width
package geofence_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        TEST = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Differences need 1 extra bit, products 2, the product difference 1 more.
    localparam int unsigned CROSS_GUARD_BITS = 3;

    function automatic int unsigned cross_width(input int unsigned coord_w);
        return 2 * coord_w + CROSS_GUARD_BITS;
    endfunction

endpackage

// File: rtl/geofence_n_if.sv
// Sample / result bus of the geofence block.
//   in_valid, X, Y : sample offered by the master
//   in_ready       : slave accepts a sample this cycle
//   out_valid      : one-cycle result strobe
//   is_inside      : result, 0 whenever out_valid is 0
interface geofence_n_if #(
    parameter int unsigned COORD_W = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               out_valid;
    logic               is_inside;

    modport master (
        output in_valid, X, Y,
        input  in_ready, out_valid, is_inside
    );

    modport slave (
        input  in_valid, X, Y,
        output in_ready, out_valid, is_inside
    );
endinterface

// File: rtl/geofence_cross.sv
// Combinational 2-D cross product a x b = ax*by - ay*bx at full precision.
//   ax, ay, bx, by : signed difference vectors, COORD_W+1 bits
//   cross_c        : signed result, 2*COORD_W+3 bits
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int unsigned COORD_W = 10
) (
    input  logic signed [COORD_W:0]                  ax,
    input  logic signed [COORD_W:0]                  ay,
    input  logic signed [COORD_W:0]                  bx,
    input  logic signed [COORD_W:0]                  by,
    output logic signed [cross_width(COORD_W)-1:0]   cross_c
);

    localparam int unsigned PROD_W  = 2 * COORD_W + 2;
    localparam int unsigned CROSS_W = cross_width(COORD_W);

    logic signed [PROD_W-1:0] p_xy;
    logic signed [PROD_W-1:0] p_yx;

    assign p_xy    = PROD_W'(ax) * PROD_W'(by);
    assign p_yx    = PROD_W'(ay) * PROD_W'(bx);
    assign cross_c = CROSS_W'(p_xy) - CROSS_W'(p_yx);

endmodule

// File: rtl/geofence_n.sv
// Point-in-convex-polygon test. Each group is one point P followed by
// NUM_VERT vertices in any order; the vertices are sorted counter-clockwise
// around V[0] by a fixed-length bubble sort, then P is tested against every
// edge, one edge per cycle, with a single shared cross-product unit.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : geofence_n_if slave (in_valid/in_ready/X/Y, out_valid/is_inside)
// Build option: define GEOFENCE_EDGE_INCL_EN to count boundary points as inside.
module geofence_n
    import geofence_pkg::*;
#(
    parameter int unsigned NUM_VERT = 6,
    parameter int unsigned COORD_W  = 10
) (
    input  logic         clk,
    input  logic         reset,
    geofence_n_if.slave  bus
);

    localparam int unsigned IDX_W   = $clog2(NUM_VERT);
    localparam int unsigned DIFF_W  = COORD_W + 1;
    localparam int unsigned CROSS_W = cross_width(COORD_W);

    localparam logic [IDX_W-1:0] LAST_VERT = IDX_W'(NUM_VERT - 1);
    localparam logic [IDX_W-1:0] SORT_LAST = IDX_W'(NUM_VERT - 2);
    localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(NUM_VERT - 3);

    state_t state_q, state_d;

    logic [COORD_W-1:0] px_q, py_q;
    logic [COORD_W-1:0] vx_q [NUM_VERT];
    logic [COORD_W-1:0] vy_q [NUM_VERT];

    logic               have_p_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   pass_q;
    logic               all_ok_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               is_inside_q;

    logic               accept;
    logic               last_vert;
    logic [IDX_W-1:0]   sel_base, sel_a, sel_b;
    logic               use_p;
    logic               sort_done;
    logic [COORD_W-1:0] base_x, base_y, a_x, a_y, b_x, b_y;
    logic signed [DIFF_W-1:0]  ax, ay, bx, by;
    logic signed [CROSS_W-1:0] cross_val;
    logic               swap;
    logic               edge_ok;

    assign accept    = bus.in_valid && in_ready_q;
    assign last_vert = accept && have_p_q && (idx_q == LAST_VERT);

    // Next state and operand selection for the shared cross unit.
    always_comb begin
        state_d   = state_q;
        sel_base  = '0;
        sel_a     = '0;
        sel_b     = '0;
        use_p     = 1'b0;
        sort_done = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (last_vert) state_d = SORT;
            end
            SORT: begin
                sel_a     = idx_q;
                sel_b     = idx_q + IDX_W'(1);
                sort_done = (pass_q == PASS_LAST) && (idx_q == SORT_LAST);
                if (sort_done) state_d = TEST;
            end
            TEST: begin
                sel_base = idx_q;
                sel_a    = (idx_q == LAST_VERT) ? '0 : idx_q + IDX_W'(1);
                use_p    = 1'b1;
                if (idx_q == LAST_VERT) state_d = OUT;
            end
            OUT: begin
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // SORT: (V[j]-V[0]) x (V[j+1]-V[0]);  TEST: (V[i+1]-V[i]) x (P-V[i]).
    assign base_x = vx_q[sel_base];
    assign base_y = vy_q[sel_base];
    assign a_x    = vx_q[sel_a];
    assign a_y    = vy_q[sel_a];
    assign b_x    = use_p ? px_q : vx_q[sel_b];
    assign b_y    = use_p ? py_q : vy_q[sel_b];

    assign ax = $signed({1'b0, a_x}) - $signed({1'b0, base_x});
    assign ay = $signed({1'b0, a_y}) - $signed({1'b0, base_y});
    assign bx = $signed({1'b0, b_x}) - $signed({1'b0, base_x});
    assign by = $signed({1'b0, b_y}) - $signed({1'b0, base_y});

    geofence_cross #(
        .COORD_W (COORD_W)
    ) u_cross (
        .ax      (ax),
        .ay      (ay),
        .bx      (bx),
        .by      (by),
        .cross_c (cross_val)
    );

    // Clockwise pair gets swapped; collinear pairs stay put.
    assign swap = cross_val < 0;

`ifdef GEOFENCE_EDGE_INCL_EN
    assign edge_ok = cross_val >= 0;
`else
    assign edge_ok = cross_val > 0;
`endif

    // Point and vertex storage: capture during LOAD, reorder during SORT.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!have_p_q) begin
                px_q <= bus.X;
                py_q <= bus.Y;
            end else begin
                vx_q[idx_q] <= bus.X;
                vy_q[idx_q] <= bus.Y;
            end
        end
        if ((state_q == SORT) && swap) begin
            vx_q[sel_a] <= vx_q[sel_b];
            vy_q[sel_a] <= vy_q[sel_b];
            vx_q[sel_b] <= vx_q[sel_a];
            vy_q[sel_b] <= vy_q[sel_a];
        end
    end

    // State register, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            have_p_q    <= 1'b0;
            idx_q       <= '0;
            pass_q      <= '0;
            all_ok_q    <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            is_inside_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == OUT);
            is_inside_q <= (state_q == TEST) && (state_d == OUT) && all_ok_q && edge_ok;
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (!have_p_q) begin
                            have_p_q <= 1'b1;
                        end else if (idx_q == LAST_VERT) begin
                            have_p_q <= 1'b0;
                            idx_q    <= IDX_W'(1);
                            pass_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                SORT: begin
                    if (sort_done) begin
                        idx_q    <= '0;
                        all_ok_q <= 1'b1;
                    end else if (idx_q == SORT_LAST) begin
                        idx_q  <= IDX_W'(1);
                        pass_q <= pass_q + IDX_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                TEST: begin
                    all_ok_q <= all_ok_q && edge_ok;
                    idx_q    <= (idx_q == LAST_VERT) ? '0 : idx_q + IDX_W'(1);
                end
                OUT: begin
                    idx_q <= '0;
                end
                default: idx_q <= '0;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.is_inside = is_inside_q;

endmodule

// File: tb/tb_geofence_n.sv
// Scoreboard bench for geofence_n: a 6-vertex / 10-bit instance driven with
// directed and random hexagons, and a 3-vertex / 16-bit triangle instance.
module tb_geofence_n;

    localparam int unsigned CW  = 10;
    localparam int unsigned CW3 = 16;
    localparam int LAT6 = 23;
    localparam int LAT3 = 5;
`ifdef GEOFENCE_EDGE_INCL_EN
    localparam bit INCL = 1'b1;
`else
    localparam bit INCL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   last6 = -1000;

    bit exp6_q[$];
    int lat6_q[$];
    bit exp3_q[$];
    int lat3_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    geofence_n_if #(.COORD_W(CW))  bus  ();
    geofence_n_if #(.COORD_W(CW3)) bus3 ();

    geofence_n #(.NUM_VERT(6), .COORD_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    geofence_n #(.NUM_VERT(3), .COORD_W(CW3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: polygon given in known CCW order, P inside iff left of every edge.
    function automatic bit model_inside(input int qx[$], input int qy[$], input int px, input int py);
        int n = qx.size();
        for (int i = 0; i < n; i++) begin
            int j = (i + 1) % n;
            longint c = longint'(qx[j] - qx[i]) * longint'(py - qy[i])
                      - longint'(qy[j] - qy[i]) * longint'(px - qx[i]);
            if (INCL ? (c < 0) : (c <= 0)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic void shuffle(input int n, output int ord[$]);
        ord = {};
        for (int i = 0; i < n; i++) ord.push_back(i);
        for (int i = n - 1; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
    endfunction

    // Offer one sample until accepted; tcyc = cycle of the transfer.
    task automatic send6(input int x, input int y, input int gap_max, output int tcyc);
        int gap;
        bit done;
        gap  = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        done = 1'b0;
        tcyc = -1;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.X = CW'(x);
            bus.Y = CW'(y);
            if (bus.in_ready) begin
                tcyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) check("dut6_accept_timeout", 0, 1);
    endtask

    task automatic send3(input int x, input int y, output int tcyc);
        bit done;
        done = 1'b0;
        tcyc = -1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            bus3.in_valid = 1'b1;
            bus3.X = CW3'(x);
            bus3.Y = CW3'(y);
            if (bus3.in_ready) begin
                tcyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) check("dut3_accept_timeout", 0, 1);
    endtask

    task automatic group6(input int px, input int py, input int qx[$], input int qy[$],
                          input int gap_max, input bit expect_out, input bit exp_in);
        int ord[$];
        int t;
        shuffle(qx.size(), ord);
        send6(px, py, gap_max, t);
        foreach (ord[k]) send6(qx[ord[k]], qy[ord[k]], gap_max, t);
        if (expect_out && t >= 0) begin
            exp6_q.push_back(exp_in);
            lat6_q.push_back(t + LAT6);
        end
        last6 = t;
    endtask

    task automatic group3(input int px, input int py, input int qx[$], input int qy[$], input bit exp_in);
        int ord[$];
        int t;
        shuffle(qx.size(), ord);
        send3(px, py, t);
        foreach (ord[k]) send3(qx[ord[k]], qy[ord[k]], t);
        @(negedge clk);
        bus3.in_valid = 1'b0;
        if (t >= 0) begin
            exp3_q.push_back(exp_in);
            lat3_q.push_back(t + LAT3);
        end
    endtask

    // Monitor for the hexagon instance: result, latency and busy window.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                if (exp6_q.size() == 0) check("dut6_unexpected_out_valid", 1, 0);
                else begin
                    check("dut6_is_inside", bus.is_inside, exp6_q.pop_front());
                    check("dut6_latency_cycle", cyc, lat6_q.pop_front());
                end
            end else begin
                check("dut6_is_inside_idle", bus.is_inside, 0);
            end
            if (cyc > last6 && cyc <= last6 + LAT6) check("dut6_in_ready_busy", bus.in_ready, 0);
            else if (cyc == last6 + LAT6 + 1) check("dut6_in_ready_back", bus.in_ready, 1);
        end
    end

    // Monitor for the triangle instance.
    always @(negedge clk) begin
        if (!reset && bus3.out_valid) begin
            if (exp3_q.size() == 0) check("dut3_unexpected_out_valid", 1, 0);
            else begin
                check("dut3_is_inside", bus3.is_inside, exp3_q.pop_front());
                check("dut3_latency_cycle", cyc, lat3_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hx[$];
        int hy[$];
        int tx[$];
        int ty[$];
        int qx[$];
        int qy[$];
        int sc, ox, oy, px, py, e, t;
        bit shp;

        hx = '{100, 200, 250, 200, 100, 50};
        hy = '{0, 0, 100, 200, 200, 100};
        tx = '{0, 65535, 0};
        ty = '{0, 0, 65535};

        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        bus3.in_valid = 1'b0;
        bus3.X = '0;
        bus3.Y = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_is_inside", bus.is_inside, 0);
        reset = 1'b0;
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1);

        // Directed hexagon cases.
        group6(150, 100, hx, hy, 2, 1'b1, 1'b1);
        group6(300, 100, hx, hy, 1, 1'b1, 1'b0);
        group6(0, 0, hx, hy, 0, 1'b1, 1'b0);
        group6(150, 0, hx, hy, 1, 1'b1, INCL);

        // Reset while sorting: group is dropped.
        group6(150, 100, hx, hy, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        last6 = -1000;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("sort_reset_in_ready", bus.in_ready, 1);
        group6(150, 100, hx, hy, 1, 1'b1, 1'b1);

        // Reset part-way through loading: next transfer is a fresh P.
        send6(300, 300, 0, t);
        send6(100, 0, 0, t);
        send6(200, 0, 0, t);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("load_reset_in_ready", bus.in_ready, 1);
        group6(150, 100, hx, hy, 0, 1'b1, 1'b1);

        // Back-to-back groups with in_valid held high throughout.
        for (int g = 0; g < 3; g++) begin
            px = int'($urandom_range(300, 0));
            py = int'($urandom_range(220, 0));
            group6(px, py, hx, hy, 0, 1'b1, model_inside(hx, hy, px, py));
        end

        // Random scaled/translated convex hexagons with random points.
        for (int g = 0; g < 16; g++) begin
            sc  = int'($urandom_range(3, 1));
            ox  = int'($urandom_range(250, 0));
            oy  = int'($urandom_range(250, 0));
            shp = 1'($urandom_range(1, 0));
            if (shp) begin
                qx = '{0, 60, 180, 220, 150, 30};
                qy = '{50, 0, 20, 120, 200, 170};
            end else begin
                qx = hx;
                qy = hy;
            end
            foreach (qx[k]) begin
                qx[k] = qx[k] * sc + ox;
                qy[k] = qy[k] * sc + oy;
            end
            if ($urandom_range(3, 0) == 0) begin
                e  = int'($urandom_range(5, 0));
                px = (qx[e] + qx[(e + 1) % 6]) / 2;
                py = (qy[e] + qy[(e + 1) % 6]) / 2;
            end else begin
                px = clamp(ox - 10 + int'($urandom_range(sc * 270, 0)), 1023);
                py = clamp(oy - 10 + int'($urandom_range(sc * 220, 0)), 1023);
            end
            group6(px, py, qx, qy, int'($urandom_range(3, 0)), 1'b1, model_inside(qx, qy, px, py));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;

        // Full-range triangle on the 16-bit instance.
        group3(1, 1, tx, ty, 1'b1);
        group3(65535, 65535, tx, ty, 1'b0);
        group3(32767, 32768, tx, ty, INCL);
        for (int g = 0; g < 4; g++) begin
            px = int'($urandom_range(65535, 0));
            py = int'($urandom_range(65535, 0));
            group3(px, py, tx, ty, model_inside(tx, ty, px, py));
        end

        for (int k = 0; k < 200 && (exp6_q.size() != 0 || exp3_q.size() != 0); k++) @(negedge clk);
        check("dut6_pending_results", exp6_q.size(), 0);
        check("dut3_pending_results", exp3_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
